// File: rtl/mux_scan_serializer_pkg.sv
// Shared types and constants for the byte-to-bit scan serializer.
package mux_scan_serializer_pkg;

  localparam int WORD_BITS = 8;
  localparam int SEL_W     = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_PAR,
    ST_GAP
  } state_e;

  // Maps the beat counter onto the select-tree position for the chosen bit order.
  function automatic logic [SEL_W-1:0] scan_sel(input logic [SEL_W-1:0] cnt,
                                                input logic              msb_first);
    return msb_first ? (SEL_W'(WORD_BITS - 1) - cnt) : cnt;
  endfunction

endpackage

// File: rtl/mux_scan_serializer_mux8to1.sv
// 8:1 select tree: routes one bit of the data word to the output.
module mux8to1 (
  input  logic [7:0] d,
  input  logic [2:0] sel,
  output logic       y
);

  assign y = d[sel];

endmodule

// File: rtl/mux_scan_serializer.sv
// Parallel-to-serial front end: latches a byte, scans the 8:1 tree through all
// positions and emits a serial stream with first/last markers and optional parity.
module mux_scan_serializer
  import mux_scan_serializer_pkg::*;
#(
  parameter int MSB_FIRST  = 0,
  parameter int PARITY_EN  = 0,
  parameter int GAP_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       ser_valid,
  output logic       ser_data,
  input  logic       ser_ready,
  output logic       ser_first,
  output logic       ser_last,
  output logic       busy
);

  localparam logic             MSB_BIT  = (MSB_FIRST != 0);
  localparam logic             PAR_BIT  = (PARITY_EN != 0);
  localparam logic             HAS_GAP  = (GAP_CYCLES > 0);
  localparam logic [3:0]       GAP_LAST = 4'(GAP_CYCLES - 1);
  localparam logic [SEL_W-1:0] CNT_LAST = SEL_W'(WORD_BITS - 1);

  state_e               state_q, state_d;
  logic [WORD_BITS-1:0] data_q, data_d;
  logic [SEL_W-1:0]     cnt_q, cnt_d;
  logic                 parity_q, parity_d;
  logic [3:0]           gap_q, gap_d;

  logic [SEL_W-1:0]     sel;
  logic                 tree_y;

  assign sel = scan_sel(cnt_q, MSB_BIT);

  mux8to1 u_tree (
    .d   (data_q),
    .sel (sel),
    .y   (tree_y)
  );

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    parity_d = parity_q;
    gap_d    = gap_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d   = in_data;
          cnt_d    = '0;
          parity_d = 1'b0;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (ser_ready) begin
          parity_d = parity_q ^ tree_y;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            if (PAR_BIT)      state_d = ST_PAR;
            else if (HAS_GAP) state_d = ST_GAP;
            else              state_d = ST_IDLE;
          end
        end
      end
      ST_PAR: begin
        if (ser_ready) state_d = HAS_GAP ? ST_GAP : ST_IDLE;
      end
      ST_GAP: begin
        // gap_q is zero on entry; leave after exactly GAP_CYCLES cycles here.
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      data_q   <= '0;
      cnt_q    <= '0;
      parity_q <= 1'b0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      parity_q <= parity_d;
      gap_q    <= gap_d;
    end
  end

  // Every output is a decode of registered state; handshake inputs never reach them.
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    busy      = (state_q != ST_IDLE);
    ser_valid = (state_q == ST_SHIFT) || (state_q == ST_PAR);
    ser_first = (state_q == ST_SHIFT) && (cnt_q == '0);
    ser_last  = ((state_q == ST_SHIFT) && (cnt_q == CNT_LAST) && !PAR_BIT) ||
                (state_q == ST_PAR);
    ser_data  = 1'b0;
    if (state_q == ST_SHIFT)    ser_data = tree_y;
    else if (state_q == ST_PAR) ser_data = parity_q;
  end

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Bench for mux_scan_serializer: two configurations driven by directed and random words.
module tb_mux_scan_serializer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid  [2];
  logic [7:0] in_data   [2];
  logic       ser_ready [2];
  logic       in_ready  [2];
  logic       ser_valid [2];
  logic       ser_data  [2];
  logic       ser_first [2];
  logic       ser_last  [2];
  logic       busy      [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instance 0: LSB first, parity trailer, two gap cycles.
  mux_scan_serializer #(.MSB_FIRST(0), .PARITY_EN(1), .GAP_CYCLES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_data(in_data[0]),
    .in_ready(in_ready[0]), .ser_valid(ser_valid[0]), .ser_data(ser_data[0]),
    .ser_ready(ser_ready[0]), .ser_first(ser_first[0]), .ser_last(ser_last[0]),
    .busy(busy[0])
  );

  // Instance 1: MSB first, no parity, no gap.
  mux_scan_serializer #(.MSB_FIRST(1), .PARITY_EN(0), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_data(in_data[1]),
    .in_ready(in_ready[1]), .ser_valid(ser_valid[1]), .ser_data(ser_data[1]),
    .ser_ready(ser_ready[1]), .ser_first(ser_first[1]), .ser_last(ser_last[1]),
    .busy(busy[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input int d, input string tag);
    chk({tag, "_in_ready"},  32'(in_ready[d]),  1);
    chk({tag, "_ser_valid"}, 32'(ser_valid[d]), 0);
    chk({tag, "_ser_first"}, 32'(ser_first[d]), 0);
    chk({tag, "_ser_last"},  32'(ser_last[d]),  0);
    chk({tag, "_ser_data"},  32'(ser_data[d]),  0);
    chk({tag, "_busy"},      32'(busy[d]),      0);
  endtask

  // Sends one word on instance d and checks every beat against a bit list built
  // from the word. rst_at >= 0 asserts reset when that beat is on the bus.
  task automatic send(input int d, input logic [7:0] w, input bit rnd_bp,
                      input int stall_at, input int stall_len, input int rst_at);
    logic exp_q[$];
    int   gap, idx, stalled, guard;
    bit   msb, par, rdy;
    msb = (d == 1);
    par = (d == 0);
    gap = (d == 0) ? 2 : 0;
    for (int k = 0; k < 8; k++) exp_q.push_back(w[msb ? 7 - k : k]);
    if (par) exp_q.push_back(^w);

    guard = 0;
    while (!in_ready[d] && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("wait_in_ready", 32'(in_ready[d]), 1);
    in_valid[d] = 1'b1;
    in_data[d]  = w;
    @(negedge clk);
    in_valid[d] = 1'b0;
    chk("latency_valid", 32'(ser_valid[d]), 1);
    chk("latency_busy",  32'(busy[d]),      1);

    idx = 0; stalled = 0; guard = 0;
    while (idx < exp_q.size() && guard < 300) begin
      guard++;
      if (idx == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk_idle(d, "rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle(d, "rst_after");
        return;
      end
      chk("beat_valid", 32'(ser_valid[d]), 1);
      chk("beat_data",  32'(ser_data[d]),  32'(exp_q[idx]));
      chk("beat_first", 32'(ser_first[d]), 32'(idx == 0));
      chk("beat_last",  32'(ser_last[d]),  32'(idx == exp_q.size() - 1));
      chk("beat_in_ready", 32'(in_ready[d]), 0);
      if (idx == stall_at && stalled < stall_len) begin
        rdy = 1'b0;
        stalled++;
      end else begin
        rdy = rnd_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      ser_ready[d] = rdy;
      in_valid[d]  = 1'($urandom_range(0, 1));
      in_data[d]   = 8'($urandom);
      @(negedge clk);
      in_valid[d] = 1'b0;
      if (rdy) idx++;
    end
    chk("beats_done", 32'(idx), 32'(exp_q.size()));
    ser_ready[d] = 1'b1;
    for (int g = 0; g < gap; g++) begin
      chk("gap_in_ready",  32'(in_ready[d]),  0);
      chk("gap_ser_valid", 32'(ser_valid[d]), 0);
      chk("gap_busy",      32'(busy[d]),      1);
      @(negedge clk);
    end
    chk("end_in_ready",  32'(in_ready[d]),  1);
    chk("end_busy",      32'(busy[d]),      0);
    chk("end_ser_valid", 32'(ser_valid[d]), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_valid[d]  = 1'b0;
      in_data[d]   = 8'h00;
      ser_ready[d] = 1'b1;
    end
    repeat (2) @(negedge clk);
    chk_idle(0, "reset_a");
    chk_idle(1, "reset_b");
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle(0, "post_reset_a");
    chk_idle(1, "post_reset_b");

    send(0, 8'hA5, 1'b0, -1, 0, -1);
    send(0, 8'h07, 1'b0, -1, 0, -1);
    send(0, 8'h03, 1'b0, -1, 0, -1);
    send(0, 8'h5A, 1'b0, 3, 3, -1);
    send(0, 8'hFF, 1'b0, -1, 0, -1);
    send(0, 8'h0F, 1'b0, -1, 0, 4);
    send(0, 8'h3C, 1'b0, -1, 0, -1);

    send(1, 8'h81, 1'b0, -1, 0, -1);
    send(1, 8'h40, 1'b0, -1, 0, -1);
    send(1, 8'hA5, 1'b0, 5, 2, -1);

    for (int i = 0; i < 15; i++) begin
      send(0, 8'($urandom), 1'b1, -1, 0, -1);
      send(1, 8'($urandom), 1'b1, -1, 0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_scan_serializer.md
Name: mux_scan_serializer

Overview:
- Parallel-to-serial front end built around the 8:1 select tree.
- Accepts an 8-bit word over a valid/ready handshake and registers it onto the tree's 8-bit data input.
- Sequences the 3-bit select through all eight positions and emits the tree output as a serial bit stream with valid/ready, first/last markers and an optional even-parity trailer.
- Sits between a byte-wide producer and a bit-serial consumer.

Parameters:
- MSB_FIRST, 0, 0: select order 0..7 (LSB first); 1: select order 7..0.
- PARITY_EN, 0, 1: append one even-parity beat (XOR of the 8 data bits) after the data bits.
- GAP_CYCLES, 0, idle cycles inserted after the last beat before in_ready reasserts (0..15).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  producer has a word.
- in_data  input  8  word to serialize.
- in_ready  output  1  block can accept a word.
- ser_valid  output  1  ser_data is a valid beat.
- ser_data  output  1  current serial bit (select-tree output, or the parity bit).
- ser_ready  input  1  consumer accepts the beat.
- ser_first  output  1  marks the first beat of a word.
- ser_last  output  1  marks the final beat of a word.
- busy  output  1  word in flight: any state other than IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state IDLE, data_q=0, cnt=0, parity=0, gap_cnt=0. Resulting outputs: in_ready=1, ser_valid=0, ser_first=0, ser_last=0, ser_data=0, busy=0.
- States: IDLE, SHIFT, PAR, GAP.
  - All outputs are decoded from registered state only.
  - There is no combinational path from ser_ready or in_valid to any output.
- IDLE:
  - in_ready=1.
  - On in_valid: data_q<=in_data, cnt<=0, parity<=0, next state SHIFT.
- SHIFT:
  - ser_valid=1.
  - sel = MSB_FIRST ? 7-cnt : cnt; ser_data = tree output.
  - ser_first = (cnt==0).
  - ser_last = (cnt==7 && !PARITY_EN).
  - On ser_ready: parity ^= ser_data; cnt++.
  - On ser_ready with cnt==7, next state is PAR if PARITY_EN, else GAP if GAP_CYCLES>0, else IDLE. cnt wraps to 0.
- PAR:
  - ser_valid=1, ser_data=parity, ser_last=1.
  - On ser_ready: next state GAP if GAP_CYCLES>0, else IDLE.
- GAP:
  - Counts GAP_CYCLES cycles, then goes to IDLE.
  - ser_valid=0, in_ready=0.
- Latency: the first beat is valid in the cycle after the accepting in_valid&&in_ready edge.
- Throughput with ser_ready=1: one word per 8+PARITY_EN+GAP_CYCLES+1 cycles. The +1 is the IDLE accept cycle; there is no back-to-back accept.
- Backpressure: while ser_valid && !ser_ready, ser_data, ser_first, ser_last, sel and cnt hold stable.
- in_valid outside IDLE is ignored; in_data is not sampled.
- data_q is held unchanged for the whole word, so the tree data input is stable.
- rst_n asserted mid-word aborts the word immediately. No further beats are emitted and no partial word is replayed.

Decomposition:
- Shared package:
  - State enum (IDLE, SHIFT, PAR, GAP).
  - Constant WORD_BITS=8.
  - Constant SEL_W=3.
- Sub-module: one instance of the existing mux8to1, driven by data_q and sel, with its output routed to ser_data.
- The controller (FSM, counters, parity) stays in this module.

Test Plan:
- Basic LSB-first: MSB_FIRST=0, load 0xA5, ser_ready=1. Beats are 1,0,1,0,0,1,0,1 over 8 consecutive cycles; ser_first on beat 0, ser_last on beat 7; in_ready=0 for 8 cycles then 1.
- MSB-first: MSB_FIRST=1, load 0x81 then 0x40. Beats are 1,0,0,0,0,0,0,1 then 0,1,0,0,0,0,0,0; exactly one IDLE cycle between the words.
- Parity: PARITY_EN=1, load 0x07. Beats are 1,1,1,0,0,0,0,0 then parity 1; ser_last only on the 9th beat. Load 0x03: parity beat is 0.
- Backpressure: load 0x5A, drop ser_ready for 3 cycles while cnt==3. ser_data stays 1 (bit 3) and cnt stays at 3 through the stall; the full word completes correctly afterwards; in_valid pulsed mid-word is ignored.
- Gap and reset: GAP_CYCLES=2, load 0xFF. in_ready returns exactly 2 cycles after the last accepted beat. Then load 0x0F and assert rst_n low at beat 4: ser_valid=0 immediately, and after release in_ready=1 and busy=0.
